// File: rtl/sig_pack_ctrl.sv
// Purpose : collects NSIG signed samples into slot registers, strobes an external packer and returns its word downstream.
// Latency : last sample accepted in cycle N -> combine_sig_s in N+1 -> out_valid from N+3.
// Backpressure: in_ready is low outside FILL; out_data is held stable while out_valid waits for out_ready.
//
// Ports:
//   clk_fast, rst             single clock, synchronous active-high reset
//   in_valid/in_ready/in_data upstream sample handshake (WIDTH-bit two's complement)
//   flush                     closes a partial frame, remaining slots zero-padded
//   sin_bus, combine_sig_s    slot registers and one-cycle capture strobe to the packer
//   Sout_s                    packer registered result, sampled one cycle after the strobe
//   out_valid/out_ready/out_data  downstream packed-word handshake
//   frame_cnt                 completed output handshakes, modulo 2^16
//   busy                      high whenever the controller is not filling
module sig_pack_ctrl #(
    parameter int WIDTH = 10,
    parameter int NSIG  = 16
) (
    input  logic                   clk_fast,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   flush,
    output logic [WIDTH*NSIG-1:0]  sin_bus,
    output logic                   combine_sig_s,
    input  logic [WIDTH*NSIG-1:0]  Sout_s,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*NSIG-1:0]  out_data,
    output logic [15:0]            frame_cnt,
    output logic                   busy
);

    localparam int CW = (NSIG > 1) ? $clog2(NSIG) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NSIG - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMBINE = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] slot [NSIG];

    logic accept;
    logic close_frame;
    logic handshake;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // A frame closes when the last slot is written, or on flush provided the
    // frame holds at least one sample (counting one accepted this cycle).
    assign close_frame = (state == FILL) &&
                         ((accept && ((cnt == LAST_SLOT) || flush)) ||
                          (!accept && flush && (cnt != '0)));

    // State register
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (close_frame) state_nxt = COMBINE;
            COMBINE: state_nxt = CAPTURE;
            CAPTURE: state_nxt = OUT;
            OUT:     if (handshake) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Output decode; in_ready is forced low while reset is held.
    always_comb begin
        in_ready  = (state == FILL) && !rst;
        out_valid = (state == OUT);
        busy      = (state != FILL);
    end

    // Strobe is registered from the next state; COMBINE is only entered from
    // FILL, so the strobe can never be high in two consecutive cycles.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            combine_sig_s <= 1'b0;
        end else begin
            combine_sig_s <= (state_nxt == COMBINE);
        end
    end

    // Slot fill, padding, output capture and frame counting
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            cnt       <= '0;
            out_data  <= '0;
            frame_cnt <= '0;
            for (int k = 0; k < NSIG; k++) begin
                slot[k] <= '0;
            end
        end else begin
            if (state == FILL) begin
                if (close_frame) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt <= cnt + CW'(1);
                end
                // Sample lands in slot[cnt]; on close every later slot is zeroed.
                for (int k = 0; k < NSIG; k++) begin
                    if (accept && (cnt == CW'(k))) begin
                        slot[k] <= in_data;
                    end else if (close_frame && (CW'(k) >= cnt)) begin
                        slot[k] <= '0;
                    end
                end
            end

            if (state == CAPTURE) begin
                out_data <= Sout_s;
            end

            if (handshake) begin
                frame_cnt <= frame_cnt + 16'd1;
                for (int k = 0; k < NSIG; k++) begin
                    slot[k] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < NSIG; g++) begin : g_sin_bus
        assign sin_bus[g*WIDTH +: WIDTH] = slot[g];
    end

endmodule
